// File: rtl/serial_feeder_if.sv
// rtl/serial_feeder_if.sv - byte write handshake between a producer and serial_feeder
interface serial_feeder_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic [LW-1:0] level;

    modport master (
        output wr_en,
        output wr_data,
        input  full,
        input  level
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output full,
        output level
    );
endinterface

// File: rtl/serial_feeder.sv
// rtl/serial_feeder.sv - FIFO-buffered LSB-first byte feeder for an 8-bit mode-controlled shift register
// Optional flush/zero feature: define FEEDER_CLEAR_EN to add the clr port and CLEAR state.
module serial_feeder #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_feeder_if.slave     wif,
    input  logic [7:0]         reg_q,
    output logic [2:0]         reg_mode,
    output logic [7:0]         reg_in,
    output logic               reg_single,
    output logic               busy,
    output logic               byte_done
`ifdef FEEDER_CLEAR_EN
    ,
    input  logic               clr
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
`ifdef FEEDER_CLEAR_EN
        ,
        ST_CLEAR = 2'd2
`endif
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    cnt, cnt_nxt;
    logic [7:0]    sbuf;
    logic          done_nxt;
    logic          pop;
    logic          push;
    logic [AW-1:0] wptr, rptr;
    logic [LW-1:0] level_q;
    logic [7:0]    mem [DEPTH];

    assign wif.full  = (level_q == LW'(DEPTH));
    assign wif.level = level_q;
    assign reg_in    = reg_q;
    assign busy      = (state == ST_SHIFT);

    // full is judged on the pre-pop level, so a write into a full FIFO is dropped even on a pop edge
`ifdef FEEDER_CLEAR_EN
    assign push = wif.wr_en && !wif.full && !clr;
`else
    assign push = wif.wr_en && !wif.full;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (level_q != '0) begin
                    pop       = 1'b1;
                    cnt_nxt   = 3'd0;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    done_nxt = 1'b1;
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        cnt_nxt = 3'd0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
`ifdef FEEDER_CLEAR_EN
        // an aborted byte never reports completion
        if (clr) begin
            pop       = 1'b0;
            done_nxt  = 1'b0;
            cnt_nxt   = 3'd0;
            state_nxt = ST_CLEAR;
        end
`endif
    end

    // register controls decode from registered state only, so they settle well before the negedge
    always_comb begin
        reg_mode   = 3'd1;
        reg_single = 1'b0;
        case (state)
            ST_SHIFT: begin
                reg_mode   = 3'd5;
                reg_single = sbuf[cnt];
            end
`ifdef FEEDER_CLEAR_EN
            ST_CLEAR: reg_mode = 3'd0;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            sbuf      <= 8'h00;
            byte_done <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            level_q   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            byte_done <= done_nxt;
            if (pop) begin
                sbuf <= mem[rptr];
                rptr <= rptr + AW'(1);
            end
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            level_q <= level_q + LW'(push) - LW'(pop);
`ifdef FEEDER_CLEAR_EN
            if (clr) begin
                rptr    <= wptr;
                level_q <= '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wif.wr_data;
        end
    end
endmodule
